// File: rtl/mux_pkg.sv
// Shared types for the two-way data selector and its pipeline register.
package mux_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} mux_sel_e;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/pipe_reg.sv
// WIDTH-bit pipeline register with valid bit; priority reset > flush > stall > load.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);
  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  // Data loads even when i_valid is low; consumers qualify with o_valid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_q     <= RESET_VAL;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_q     <= i_d;
      r_valid <= i_valid;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;
endmodule

// File: rtl/mux2_input_reg.sv
// Two-way selector: combinational out plus a one-cycle registered copy with valid.
module mux2_input_reg
  import mux_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);
  mux_sel_e         w_sel;
  logic [WIDTH-1:0] w_mux;

  assign w_sel = mux_sel_e'(select);
  assign w_mux = (w_sel == SEL_B) ? b : a;
  assign out   = w_mux;

  pipe_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_pipe_reg (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .stall   (stall),
    .i_d     (w_mux),
    .i_valid (in_valid),
    .o_q     (out_q),
    .o_valid (out_valid)
  );
endmodule

// File: tb/tb_mux2_input_reg.sv
// Directed and randomized checks of mux2_input_reg against a reference model.
module tb_mux2_input_reg;
  logic        clk = 1'b0;
  logic        reset, select, in_valid, stall, flush;
  logic [31:0] a, b, out, out_q;
  logic        out_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q;
  logic        exp_v;

  always #5 clk = ~clk;

  mux2_input_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .select    (select),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from the low phase, check the comb path,
  // advance the model at the rising edge, and check the registered stage.
  task automatic cyc(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                     input logic iv, input logic st, input logic fl, input logic rs);
    a = ia; b = ib; select = is; in_valid = iv; stall = st; flush = fl; reset = rs;
    #1;
    chk("out", out, is ? ib : ia);
    @(posedge clk);
    if (rs || fl) begin
      exp_q = 32'h0;
      exp_v = 1'b0;
    end else if (!st) begin
      exp_q = is ? ib : ia;
      exp_v = iv;
    end
    @(negedge clk);
    chk("out_q", out_q, exp_q);
    chk("out_valid", {31'h0, out_valid}, {31'h0, exp_v});
  endtask

  initial begin
    a = '0; b = '0; select = 0; in_valid = 0; stall = 0; flush = 0; reset = 1;
    exp_q = '0; exp_v = 0;
    @(negedge clk);

    // Reset for two cycles, even with valid data offered.
    cyc(32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0, 1);
    cyc(32'h1111_1111, 32'h2222_2222, 0, 1, 0, 0, 1);
    chk("rst_q", out_q, 32'h0);
    chk("rst_v", {31'h0, out_valid}, 32'h0);

    // Combinational path follows select with no clock edge.
    a = 32'h1234_5678; b = 32'h8765_4321; select = 0; #1;
    chk("comb_a", out, 32'h1234_5678);
    select = 1; #1;
    chk("comb_b", out, 32'h8765_4321);
    select = 0; #1;
    chk("comb_back", out, 32'h1234_5678);

    cyc(32'h0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0);
    chk("load_q", out_q, 32'hDEAD_BEEF);
    chk("load_v", {31'h0, out_valid}, 32'h1);

    // Stall holds the stage while out keeps tracking.
    cyc(32'hA5A5_A5A5, 32'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc($urandom, $urandom, 1'($urandom), 1'($urandom), 1, 0, 0);
    chk("stall_q", out_q, 32'hA5A5_A5A5);
    chk("stall_v", {31'h0, out_valid}, 32'h1);

    // Flush beats stall.
    cyc($urandom, $urandom, 1, 1, 1, 1, 0);
    chk("flush_q", out_q, 32'h0);
    chk("flush_v", {31'h0, out_valid}, 32'h0);

    // in_valid low still loads data but not the valid flag.
    cyc(32'h0BAD_F00D, 32'h0, 0, 0, 0, 0, 0);
    chk("noval_q", out_q, 32'h0BAD_F00D);
    chk("noval_v", {31'h0, out_valid}, 32'h0);

    // All-ones / all-zeros alternation.
    for (int i = 0; i < 8; i++) begin
      cyc(32'hFFFF_FFFF, 32'h0, 1'(i & 1), 1, 0, 0, 0);
      chk("alt_q", out_q, (i & 1) ? 32'h0 : 32'hFFFF_FFFF);
    end

    // Reset mid-stream discards pending valid data.
    cyc(32'hCAFE_0001, 32'h0, 0, 1, 0, 0, 0);
    cyc(32'h1, 32'h2, 1, 1, 0, 0, 1);
    chk("midrst_v", {31'h0, out_valid}, 32'h0);

    // Randomized traffic with occasional control events.
    for (int i = 0; i < 400; i++)
      cyc($urandom, $urandom, 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
